// File: rtl/line_sum_window_accumulator_pkg.sv
// line_sum_pkg: shared channel map, default widths and channel-count helper for the line-sum accumulator
package line_sum_pkg;
  localparam int CH_ISQ = 0;
  localparam int CH_I = 1;
  localparam int CH_TXI0 = 2;
  localparam int DEF_IN_W = 24;
  localparam int DEF_MAX_LINES = 64;
  typedef logic [DEF_IN_W-1:0] line_sum_t;
  typedef logic [DEF_IN_W+$clog2(DEF_MAX_LINES)-1:0] acc_t;
  function automatic int num_ch(input int num_templates);
    return 2 + num_templates;
  endfunction
endpackage

// File: rtl/line_sum_window_accumulator_if.sv
// line_sum_window_accumulator_if: line-sum input and accumulated-result output bundle
interface line_sum_window_accumulator_if #(
  parameter int NUM_CH = 5,
  parameter int IN_W = 24,
  parameter int OUT_W = 30,
  parameter int LC_W = 7
);
  logic frame_start;
  logic in_valid;
  logic [NUM_CH-1:0][IN_W-1:0] in_sum;
  logic out_valid;
  logic [NUM_CH-1:0][OUT_W-1:0] out_sum;
  logic [LC_W-1:0] line_count;
  logic overflow;
  modport master (output frame_start, in_valid, in_sum, input out_valid, out_sum, line_count, overflow);
  modport slave (input frame_start, in_valid, in_sum, output out_valid, out_sum, line_count, overflow);
endinterface

// File: rtl/line_sum_window_accumulator_ring_buf.sv
// line_sum_ring_buf: depth x width line store; combinational read of the slot about to be overwritten
module line_sum_ring_buf #(
  parameter int DEPTH = 8,
  parameter int W = 120,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] ptr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  assign rdata_o = mem_q[ptr_i];
  always_ff @(posedge CLK or negedge reset)
    if (!reset)
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we_i)
      mem_q[ptr_i] <= wdata_i;
endmodule

// File: rtl/line_sum_window_accumulator.sv
// line_sum_window_accumulator: per-channel line-sum accumulation, cumulative or sliding over WIN_LINES lines
module line_sum_window_accumulator
  import line_sum_pkg::*;
#(
  parameter int NUM_TEMPLATES = 3,
  parameter int IN_W = 24,
  parameter int MAX_LINES = 64,
  parameter int WIN_LINES = 8,
  parameter int SLIDING = 1
) (
  input logic CLK,
  input logic reset,
  line_sum_window_accumulator_if.slave bus
);
  localparam int NUM_CH = num_ch(NUM_TEMPLATES);
  localparam int OUT_W = IN_W + $clog2(MAX_LINES);
  localparam int LC_W = $clog2(MAX_LINES + 1);
  localparam int PW = WIN_LINES > 1 ? $clog2(WIN_LINES) : 1;
  localparam int FW = $clog2(WIN_LINES + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(MAX_LINES);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIN_LINES);
  localparam logic [PW-1:0] PTR_LAST = PW'(WIN_LINES - 1);
  logic [NUM_CH-1:0][OUT_W-1:0] acc_q, acc_d, acc_b;
  logic [NUM_CH-1:0][IN_W-1:0] old_line;
  logic [LC_W-1:0] cnt_q, cnt_d, cnt_b;
  logic [FW-1:0] fill_q, fill_d, fill_b;
  logic [PW-1:0] ptr_q, ptr_d, ptr_b;
  logic ovf_q, ovf_d, vld_q, vld_d, sat, full, take;
  // frame_start clears first, so a coincident line lands as line 1 of the new frame
  always_comb begin
    acc_b = bus.frame_start ? '0 : acc_q;
    cnt_b = bus.frame_start ? '0 : cnt_q;
    fill_b = bus.frame_start ? '0 : fill_q;
    ptr_b = bus.frame_start ? '0 : ptr_q;
    sat = cnt_b == LC_MAX;
    full = SLIDING != 0 && fill_b == FILL_MAX;
    take = bus.in_valid && (SLIDING != 0 || !sat);
    cnt_d = bus.in_valid && !sat ? cnt_b + 1'b1 : cnt_b;
    ovf_d = (!bus.frame_start && ovf_q) || (bus.in_valid && sat);
    fill_d = bus.in_valid && fill_b != FILL_MAX ? fill_b + 1'b1 : fill_b;
    ptr_d = !bus.in_valid ? ptr_b : ptr_b == PTR_LAST ? '0 : ptr_b + 1'b1;
    vld_d = take && (SLIDING == 0 || fill_d == FILL_MAX);
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign acc_d[c] = take ? acc_b[c] + OUT_W'(bus.in_sum[c]) - (full ? OUT_W'(old_line[c]) : '0) : acc_b[c];
  end
  line_sum_ring_buf #(
    .DEPTH(WIN_LINES),
    .W(NUM_CH * IN_W),
    .AW(PW)
  ) u_buf (
    .CLK(CLK),
    .reset(reset),
    .we_i(bus.in_valid && SLIDING != 0),
    .ptr_i(ptr_b),
    .wdata_i(bus.in_sum),
    .rdata_o(old_line)
  );
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      fill_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  assign bus.out_sum = acc_q;
  assign bus.out_valid = vld_q;
  assign bus.line_count = cnt_q;
  assign bus.overflow = ovf_q;
endmodule
